aes_128_arb: RTL and testbench
==============================

Name: aes_128_arb

Overview:
- Round-robin arbiter and scheduler sharing one aes_128_top instance among NUM_CH requesters.
- Accepts 128-bit blocks from requesters, issues one block at a time to the core, and selects the key set via core_ch.
- Tracks in-flight blocks in an in-order tag FIFO, so each core output is returned to the requester that issued it.
- Sits between the channel front-ends and aes_128_top; drives the core's in_en and kill.

Parameters:
- NUM_CH, 4, number of requester channels (2..8).
- CH_W, 2, channel index width; must equal clog2(NUM_CH).
- MAX_INFLIGHT, 4, maximum blocks issued but not yet returned; also the tag FIFO depth (power of 2).

Ports:
- clk  in  1  clock; all logic rising-edge.
- kill_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of all in-flight work.
- req_valid  in  NUM_CH  per-channel block available.
- req_data  in  NUM_CH*128  per-channel block; channel i occupies bits [128*i+127:128*i].
- req_ready  out  NUM_CH  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
- core_in_data  out  128  block to the core.
- core_in_en  out  1  one-cycle start strobe to the core.
- core_ch  out  CH_W  channel of the issued block; drives the key-round mux; held until the next issue.
- core_kill  out  1  synchronous kill to the core.
- core_key_ready  in  1  core can accept a new block.
- core_out_data  in  128  core result.
- core_out_en  in  1  core result valid (one cycle).
- rsp_valid  out  1  result strobe; no backpressure.
- rsp_data  out  128  result block.
- rsp_ch  out  CH_W  destination channel of the result.
- inflight  out  CH_W+1 (sized to hold 0..MAX_INFLIGHT)  count of outstanding blocks.
- err  out  1  sticky: core_out_en arrived while the tag FIFO was empty.

Behaviour:
- Reset (kill_n=0, asynchronous):
  - All outputs 0.
  - Round-robin pointer = 0, so channel 0 has first priority.
  - Tag FIFO empty; FSM = IDLE.
- FSM states: IDLE, RUN, FLUSH1, FLUSH2.
  - IDLE→RUN on an issue.
  - RUN→IDLE when inflight reaches 0 with no issue that cycle.
  - Any state→FLUSH1 when flush=1.
  - FLUSH1→FLUSH2→IDLE unconditionally.
- Grant condition, combinational:
  - Required: state is IDLE or RUN, flush=0, core_key_ready=1, core_in_en=0 (at most one issue per two cycles), inflight<MAX_INFLIGHT.
  - The winner is the first channel with req_valid set, searching from pointer upward with wrap.
  - req_ready is one-hot for the winner, otherwise all zero.
- On a transfer from channel i:
  - Next cycle: core_in_en=1 for one cycle, core_in_data=req_data[i] (registered), core_ch=i.
  - Push i to the tag FIFO; pointer becomes (i+1) mod NUM_CH.
- On core_out_en=1:
  - Pop the FIFO head h.
  - Next cycle: rsp_valid=1 for one cycle, rsp_data=core_out_data (registered), rsp_ch=h.
  - Latency from core_out_en to rsp_valid is exactly 1 cycle.
- inflight arithmetic:
  - +1 on a push, -1 on a pop.
  - Push and pop in the same cycle leave it unchanged; the FIFO stays consistent.
- Boundary conditions:
  - inflight==MAX_INFLIGHT: no grants. A pop that cycle does not enable a grant in the same cycle; the grant comes next cycle.
  - core_out_en with an empty FIFO: no rsp_valid, err←1. err clears only on reset.
  - Pointer wraps from NUM_CH-1 to 0.
- flush:
  - In the flush cycle: no grant.
  - FLUSH1: core_kill=1 for one cycle. The FIFO is cleared and inflight←0. Any pending core_in_en is dropped.
  - FLUSH1 and FLUSH2: req_ready all zero; core_out_en is ignored (no rsp, no err).
  - The pointer is preserved.
- Reset mid-operation: immediate return to the reset state; in-flight tags are lost.

Test Plan:
- Single channel: after reset, req_valid=4'b0001 with FIPS-197 plaintext 00112233445566778899aabbccddeeff → req_ready[0] the same cycle, core_in_en the next cycle with core_ch=0. Model out_en with data 69c4e0d86a7b0430d8cdb78070b4c55a → rsp_valid one cycle later, rsp_ch=0, rsp_data equal to that value.
- Fairness: req_valid=4'b1111 held, core always ready, echo out_en after 10 cycles → grant order 0,1,2,3,0,…; grants are spaced ≥2 cycles apart; rsp_ch sequence matches the grant order.
- Full: core never returns results → exactly 4 grants, inflight=4, req_ready stays 0. One out_en → inflight=3, and the next grant occurs one cycle later.
- Simultaneous push/pop: align an issue with an out_en → inflight unchanged, rsp_ch equals the oldest tag, the new tag is queued behind it.
- Flush: 3 blocks in flight, pulse flush → core_kill high one cycle, inflight=0, req_ready 0 for two cycles, out_en during FLUSH1/FLUSH2 produces no rsp. The pointer continues the round-robin order afterwards.
- Error/reset: out_en with the FIFO empty → err=1 and stays high; kill_n low mid-run → all outputs 0 asynchronously and err cleared.

Source files
------------

// File: rtl/aes_128_arb.sv
// Round-robin scheduler sharing one aes_128_top among NUM_CH requesters.
// Issued channels are queued in an in-order tag FIFO. Each core result is
// returned to the channel at the head of that FIFO.
module aes_128_arb #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                  clk,
  input  logic                  kill_n,
  input  logic                  flush,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [NUM_CH*128-1:0] req_data,
  output logic [NUM_CH-1:0]     req_ready,
  output logic [127:0]          core_in_data,
  output logic                  core_in_en,
  output logic [CH_W-1:0]       core_ch,
  output logic                  core_kill,
  input  logic                  core_key_ready,
  input  logic [127:0]          core_out_data,
  input  logic                  core_out_en,
  output logic                  rsp_valid,
  output logic [127:0]          rsp_data,
  output logic [CH_W-1:0]       rsp_ch,
  output logic [CH_W:0]         inflight,
  output logic                  err
);

  localparam int unsigned   AW      = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam logic [CH_W:0] MAX_CNT = (CH_W+1)'(MAX_INFLIGHT);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH1, FLUSH2} state_t;

  state_t          state, state_nx;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] win;
  logic            found;
  logic [127:0]    sel_data;
  logic            active, grant_ok, push, pop, empty;
  logic [CH_W-1:0] tag_mem [MAX_INFLIGHT];
  logic [AW-1:0]   wr_ptr, rd_ptr;

  // Grants and pops are only live while not resetting or flushing, so every output reads 0 in reset.
  assign active   = kill_n && (state == IDLE || state == RUN);
  assign empty    = (inflight == '0);
  assign grant_ok = active && !flush && core_key_ready && !core_in_en && (inflight < MAX_CNT);
  assign push     = grant_ok && found;
  assign pop      = active && core_out_en && !empty;

  // Round-robin search from ptr upward with wrap; also selects the winner's block.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (!found && req_valid[(32'(ptr) + k) % NUM_CH]) begin
        found = 1'b1;
        win   = CH_W'((32'(ptr) + k) % NUM_CH);
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (win == CH_W'(i)) sel_data = req_data[128*i +: 128];
    end
  end

  // One-hot grant for the winner.
  always_comb begin
    req_ready = '0;
    if (push) req_ready = NUM_CH'(1) << win;
  end

  // Next-state logic; flush overrides every state.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (push) state_nx = RUN;
      RUN:     if (empty && !push) state_nx = IDLE;
      FLUSH1:  state_nx = FLUSH2;
      FLUSH2:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = FLUSH1;
  end

  // State, issue path, round-robin pointer and kill strobe.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      state        <= IDLE;
      ptr          <= '0;
      core_in_en   <= 1'b0;
      core_in_data <= '0;
      core_ch      <= '0;
      core_kill    <= 1'b0;
    end else begin
      state      <= state_nx;
      core_in_en <= push;
      core_kill  <= flush;
      if (push) begin
        core_in_data <= sel_data;
        core_ch      <= win;
        ptr          <= (win == CH_W'(NUM_CH-1)) ? '0 : win + CH_W'(1);
      end
    end
  end

  // Tag storage needs no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= win;
  end

  // Tag FIFO pointers, outstanding count, response path and sticky error.
  always_ff @(posedge clk or negedge kill_n) begin
    if (!kill_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      inflight  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_ch    <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= pop;
      if (pop) begin
        rsp_data <= core_out_data;
        rsp_ch   <= tag_mem[rd_ptr];
      end
      if (active && core_out_en && empty) err <= 1'b1;
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        inflight <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        case ({push, pop})
          2'b10:   inflight <= inflight + (CH_W+1)'(1);
          2'b01:   inflight <= inflight - (CH_W+1)'(1);
          default: inflight <= inflight;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_aes_128_arb.sv
// Directed bench for aes_128_arb: reset, single block, fairness, full, simultaneous push/pop, flush, error and async reset.
module tb_aes_128_arb;

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;

  logic         clk = 1'b0;
  logic         kill_n, flush;
  logic [3:0]   req_valid;
  logic [511:0] req_data;
  logic [3:0]   req_ready;
  logic [127:0] core_in_data;
  logic         core_in_en;
  logic [1:0]   core_ch;
  logic         core_kill;
  logic         core_key_ready;
  logic [127:0] core_out_data;
  logic         core_out_en;
  logic         rsp_valid;
  logic [127:0] rsp_data;
  logic [1:0]   rsp_ch;
  logic [2:0]   inflight;
  logic         err;

  int tests = 0;
  int fails = 0;
  logic [127:0] cd [4];

  aes_128_arb #(.NUM_CH(4), .CH_W(2), .MAX_INFLIGHT(4)) dut (
    .clk(clk), .kill_n(kill_n), .flush(flush),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .core_in_data(core_in_data), .core_in_en(core_in_en), .core_ch(core_ch),
    .core_kill(core_kill), .core_key_ready(core_key_ready),
    .core_out_data(core_out_data), .core_out_en(core_out_en),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ch(rsp_ch),
    .inflight(inflight), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    kill_n = 1'b0; flush = 1'b0; req_valid = '0; core_out_en = 1'b0;
    core_out_data = '0; core_key_ready = 1'b1;
    tick; tick;
    kill_n = 1'b1;
  endtask

  task automatic test_reset;
    kill_n = 1'b0; flush = 1'b0; core_out_en = 1'b0; core_key_ready = 1'b1;
    req_valid = 4'hf; req_data = {cd[3], cd[2], cd[1], cd[0]};
    #2;
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    tests++; if ({core_in_en, core_kill, rsp_valid, err} !== 4'b0) begin fails++; $display("FAIL reset_strobes: got %b want 0000", {core_in_en, core_kill, rsp_valid, err}); end
    tests++; if ({inflight, core_ch, rsp_ch} !== 7'b0) begin fails++; $display("FAIL reset_counts: got %b want 0", {inflight, core_ch, rsp_ch}); end
    tests++; if ({core_in_data, rsp_data} !== 256'b0) begin fails++; $display("FAIL reset_data: got %h want 0", {core_in_data, rsp_data}); end
    do_reset;
  endtask

  task automatic test_single;
    do_reset;
    req_data = {cd[3], cd[2], cd[1], PT};
    req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL single_grant: got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    #1;
    tests++; if (core_in_en !== 1'b1 || core_ch !== 2'd0) begin fails++; $display("FAIL single_issue: en=%b ch=%0d want en=1 ch=0", core_in_en, core_ch); end
    tests++; if (core_in_data !== PT) begin fails++; $display("FAIL single_in_data: got %h want %h", core_in_data, PT); end
    tests++; if (inflight !== 3'd1) begin fails++; $display("FAIL single_inflight: got %0d want 1", inflight); end
    tick;
    tests++; if (core_in_en !== 1'b0) begin fails++; $display("FAIL single_in_en_pulse: got %b want 0", core_in_en); end
    core_out_en = 1'b1; core_out_data = CT;
    tick;
    core_out_en = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0) begin fails++; $display("FAIL single_rsp: valid=%b ch=%0d want valid=1 ch=0", rsp_valid, rsp_ch); end
    tests++; if (rsp_data !== CT) begin fails++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, CT); end
    tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL single_inflight_after: got %0d want 0", inflight); end
    tick;
    tests++; if (rsp_valid !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL single_rsp_pulse: valid=%b err=%b want 0 0", rsp_valid, err); end
  endtask

  task automatic test_fairness;
    int due_q[$];
    logic [127:0] dat_q[$];
    int ng = 0, nr = 0, last = -100;
    logic [3:0] exp_r;
    do_reset;
    req_data = {cd[3], cd[2], cd[1], cd[0]};
    for (int c = 0; c < 70; c++) begin
      if (core_in_en === 1'b1) begin
        due_q.push_back(c + 10);
        dat_q.push_back(core_in_data ^ MASK);
      end
      core_out_en = 1'b0;
      if (due_q.size() > 0 && due_q[0] == c) begin
        core_out_en = 1'b1;
        core_out_data = dat_q.pop_front();
        void'(due_q.pop_front());
      end
      req_valid = (c < 40) ? 4'hf : 4'h0;
      #1;
      if (req_ready !== 4'b0) begin
        exp_r = 4'b0001 << (ng % 4);
        tests++; if (req_ready !== exp_r) begin fails++; $display("FAIL fair_order: grant %0d got %b want %b", ng, req_ready, exp_r); end
        tests++; if (c - last < 2) begin fails++; $display("FAIL fair_spacing: grant at %0d previous at %0d want gap>=2", c, last); end
        last = c;
        ng++;
      end
      if (rsp_valid === 1'b1) begin
        tests++; if (rsp_ch !== 2'(nr % 4)) begin fails++; $display("FAIL fair_rsp_ch: rsp %0d got %0d want %0d", nr, rsp_ch, nr % 4); end
        tests++; if (rsp_data !== (cd[nr % 4] ^ MASK)) begin fails++; $display("FAIL fair_rsp_data: rsp %0d got %h want %h", nr, rsp_data, cd[nr % 4] ^ MASK); end
        nr++;
      end
      tick;
    end
    core_out_en = 1'b0;
    #1;
    tests++; if (ng < 8) begin fails++; $display("FAIL fair_grant_count: got %0d want >=8", ng); end
    tests++; if (nr != ng) begin fails++; $display("FAIL fair_rsp_count: got %0d want %0d", nr, ng); end
    tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL fair_drain: inflight %0d want 0", inflight); end
  endtask

  task automatic test_full;
    int ng = 0;
    do_reset;
    req_data = {cd[3], cd[2], cd[1], cd[0]};
    req_valid = 4'hf;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready !== 4'b0) ng++;
      tick;
    end
    #1;
    tests++; if (ng != 4) begin fails++; $display("FAIL full_grants: got %0d want 4", ng); end
    tests++; if (inflight !== 3'd4) begin fails++; $display("FAIL full_inflight: got %0d want 4", inflight); end
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL full_ready: got %b want 0000", req_ready); end
    core_out_en = 1'b1; core_out_data = CT;
    #1;
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL full_pop_same_cycle: got %b want 0000", req_ready); end
    tick;
    core_out_en = 1'b0;
    #1;
    tests++; if (inflight !== 3'd3) begin fails++; $display("FAIL full_after_pop: inflight %0d want 3", inflight); end
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL full_next_grant: got %b want 0001", req_ready); end
    tests++; if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0) begin fails++; $display("FAIL full_rsp: valid=%b ch=%0d want 1 0", rsp_valid, rsp_ch); end
    tick;
    req_valid = '0;
    tests++; if (core_in_en !== 1'b1 || core_ch !== 2'd0 || inflight !== 3'd4) begin fails++; $display("FAIL full_reissue: en=%b ch=%0d infl=%0d want 1 0 4", core_in_en, core_ch, inflight); end
  endtask

  task automatic test_simul;
    do_reset;
    req_data = {cd[3], cd[2], cd[1], cd[0]};
    req_valid = 4'b0001;
    #1;
    tests++; if (req_ready !== 4'b0001) begin fails++; $display("FAIL simul_first_grant: got %b want 0001", req_ready); end
    tick;
    req_valid = '0;
    tick;
    req_valid = 4'b0100; core_out_en = 1'b1; core_out_data = CT;
    #1;
    tests++; if (req_ready !== 4'b0100 || inflight !== 3'd1) begin fails++; $display("FAIL simul_grant: ready=%b infl=%0d want 0100 1", req_ready, inflight); end
    tick;
    req_valid = '0; core_out_en = 1'b0;
    #1;
    tests++; if (inflight !== 3'd1) begin fails++; $display("FAIL simul_inflight: got %0d want 1", inflight); end
    tests++; if (rsp_valid !== 1'b1 || rsp_ch !== 2'd0 || rsp_data !== CT) begin fails++; $display("FAIL simul_rsp_old: valid=%b ch=%0d data=%h want 1 0 %h", rsp_valid, rsp_ch, rsp_data, CT); end
    tests++; if (core_in_en !== 1'b1 || core_ch !== 2'd2) begin fails++; $display("FAIL simul_issue: en=%b ch=%0d want 1 2", core_in_en, core_ch); end
    tick;
    core_out_en = 1'b1; core_out_data = PT;
    tick;
    core_out_en = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b1 || rsp_ch !== 2'd2 || rsp_data !== PT) begin fails++; $display("FAIL simul_rsp_new: valid=%b ch=%0d data=%h want 1 2 %h", rsp_valid, rsp_ch, rsp_data, PT); end
    tests++; if (inflight !== 3'd0) begin fails++; $display("FAIL simul_drain: inflight %0d want 0", inflight); end
  endtask

  task automatic test_flush;
    int ng = 0;
    do_reset;
    req_data = {cd[3], cd[2], cd[1], cd[0]};
    req_valid = 4'hf;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (req_ready !== 4'b0) ng++;
      tick;
    end
    tests++; if (ng != 3 || inflight !== 3'd3) begin fails++; $display("FAIL flush_setup: grants=%0d infl=%0d want 3 3", ng, inflight); end
    flush = 1'b1;
    #1;
    tests++; if (req_ready !== 4'b0) begin fails++; $display("FAIL flush_cycle_grant: got %b want 0000", req_ready); end
    tick;
    flush = 1'b0; core_out_en = 1'b1; core_out_data = CT;
    #1;
    tests++; if (core_kill !== 1'b1) begin fails++; $display("FAIL flush1_kill: got %b want 1", core_kill); end
    tests++; if (inflight !== 3'd0 || req_ready !== 4'b0 || core_in_en !== 1'b0) begin fails++; $display("FAIL flush1_state: infl=%0d ready=%b en=%b want 0 0000 0", inflight, req_ready, core_in_en); end
    tick;
    #1;
    tests++; if (core_kill !== 1'b0 || req_ready !== 4'b0) begin fails++; $display("FAIL flush2_state: kill=%b ready=%b want 0 0000", core_kill, req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL flush1_out_en_ignored: rsp_valid %b want 0", rsp_valid); end
    tick;
    core_out_en = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL flush2_out_en_ignored: rsp=%b err=%b want 0 0", rsp_valid, err); end
    tests++; if (req_ready !== 4'b1000) begin fails++; $display("FAIL flush_pointer: got %b want 1000", req_ready); end
    tick;
    req_valid = '0;
    tests++; if (core_in_en !== 1'b1 || core_ch !== 2'd3) begin fails++; $display("FAIL flush_resume: en=%b ch=%0d want 1 3", core_in_en, core_ch); end
  endtask

  task automatic test_err_reset;
    do_reset;
    req_data = {cd[3], cd[2], cd[1], cd[0]};
    core_out_en = 1'b1; core_out_data = CT;
    tick;
    core_out_en = 1'b0;
    #1;
    tests++; if (rsp_valid !== 1'b0 || err !== 1'b1) begin fails++; $display("FAIL err_set: rsp=%b err=%b want 0 1", rsp_valid, err); end
    tick; tick;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err); end
    req_valid = 4'b0001;
    tick;
    #2;
    kill_n = 1'b0;
    #1;
    tests++; if ({core_in_en, err, rsp_valid, core_kill} !== 4'b0 || req_ready !== 4'b0) begin fails++; $display("FAIL async_reset_strobes: en/err/rsp/kill=%b ready=%b want 0", {core_in_en, err, rsp_valid, core_kill}, req_ready); end
    tests++; if (inflight !== 3'd0 || core_in_data !== 128'b0 || core_ch !== 2'd0) begin fails++; $display("FAIL async_reset_state: infl=%0d data=%h ch=%0d want 0", inflight, core_in_data, core_ch); end
    do_reset;
  endtask

  initial begin
    cd[0] = 128'h0123456789abcdef_fedcba9876543210;
    cd[1] = 128'h1111111122222222_3333333344444444;
    cd[2] = 128'hdeadbeefcafef00d_0badc0de12345678;
    cd[3] = 128'h5555aaaa5555aaaa_9999666699996666;
    req_data = '0;
    test_reset;
    test_single;
    test_fairness;
    test_full;
    test_simul;
    test_flush;
    test_err_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
